trace_capture_unit: RTL
=======================

Name: trace_capture_unit

Overview:
- Parametrised debug trace buffer for the multicycle processor core; it is the synthesizable successor to the core's bench-level debug tap.
- Snoops the core's commit-side debug signals (pcen, pcvalue, instr, regwrite, memwrite) and records one entry per PC update into a circular buffer.
- Triggers on programmable PC breakpoints, captures a post-trigger window, then asserts halt and serves the captured trace oldest-first over a request/valid readout port.

Parameters:
- WIDTH, 8: datapath/PC width.
- INSTR_W, 32: instruction width.
- DEPTH, 16: trace entries; must be a power of 2, at least 4.
- POST_TRIG, 8: entries captured after the trigger entry; clamped internally to DEPTH-1.
- NUM_BP, 2: number of PC breakpoint comparators.

Ports:
- clk  in  1  system clock, all logic rises on posedge
- reset  in  1  asynchronous, active-high reset
- pcen  in  1  core PC-update strobe; one trace entry per asserted cycle
- pcvalue  in  WIDTH  current PC (value before update)
- instr  in  INSTR_W  current instruction register
- regwrite  in  1  core register-file write enable
- memwrite  in  1  core memory write enable
- arm  in  1  single-cycle pulse: clear buffer, start capture
- bp_en  in  NUM_BP  per-breakpoint enable
- bp_addr  in  NUM_BP*WIDTH  breakpoint PCs; bp k occupies bits [k*WIDTH +: WIDTH]
- rd_req  in  1  readout request, honoured only in DONE
- rd_valid  out  1  readout entry valid (one-cycle pulse)
- rd_pc  out  WIDTH  readout PC
- rd_instr  out  INSTR_W  readout instruction
- rd_flags  out  2  readout flags {memwrite_seen, regwrite_seen}
- count  out  $clog2(DEPTH+1)  entries currently held
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
- triggered  out  1  sticky; set on trigger, cleared by arm or reset
- halt  out  1  high exactly while state==DONE; gates the core's pcen

Behaviour:
- Reset (async, active-high): state=IDLE, pointers=0, count=0, sticky flags=0, triggered=0, halt=0, rd_valid=0, rd_pc/rd_instr/rd_flags=0. Buffer contents are don't-care.
- Sticky flags: regwrite_seen and memwrite_seen OR-accumulate every cycle, including the pcen cycle itself. They are stored with the entry and cleared on the cycle the entry is written. They are also cleared on arm.
- Entry write: happens in ARMED or POST on a cycle with pcen=1. Writes {pcvalue, instr, flags} at wr_ptr, then wr_ptr = (wr_ptr+1) mod DEPTH.
  - If count<DEPTH, count increments.
  - Otherwise the oldest entry is overwritten: rd_ptr advances and count stays at DEPTH.
- Trigger: an entry written in ARMED whose pcvalue equals any bp_addr[k] with bp_en[k]=1. The trigger entry itself is stored. Next state is POST with post_cnt loaded to the clamped POST_TRIG, and triggered is set. A trigger in POST is ignored.
- IDLE: nothing is recorded. arm -> ARMED, with a fresh buffer.
- ARMED: circular capture; trigger -> POST.
- POST: each write decrements post_cnt. A write that brings post_cnt to 0 -> DONE on the next edge. If the clamped POST_TRIG is 0, the trigger goes straight to DONE.
- DONE: halt=1 and no captures occur, even if pcen is high.
  - rd_req with count>0: the next cycle presents the entry at rd_ptr with rd_valid=1; rd_ptr advances and count decrements.
  - rd_req with count=0: rd_valid stays 0.
  - A back-to-back rd_req on consecutive cycles drains one entry per cycle.
- arm in any state: synchronous clear of pointers, count, flags and triggered; next state ARMED. arm has priority over a simultaneous pcen write and over rd_req.
- rd_req outside DONE is ignored.
- Read latency is 1 cycle. Readout data holds its value after rd_valid falls.
- Breakpoint compare is combinational on pcvalue. Registered outputs only; no combinational path from inputs to outputs.

Decomposition:
- Shared package: state encodings (TCU_IDLE/ARMED/POST/DONE), flag bit positions, and the entry-width localparam ENTRY_W = WIDTH+INSTR_W+2.
- Sub-module: trace_ram, a DEPTH x ENTRY_W storage block with one synchronous write port and one registered read port. Its read port feeds rd_* directly.

Test Plan:
- Reset during POST (count=5): count=0, state=0, halt=0 and triggered=0 immediately, without waiting for a clock edge.
- Trigger with wrap: DEPTH=16, POST_TRIG=8, bp0=0x20 enabled, 30 pcen cycles with PC 0x00..0x1D stepping +1. Trigger at 0x20 is never hit, so the unit stays ARMED with count=16 and holds PCs 0x0E..0x1D.
- Trigger and drain: same setup, PC stream continues to 0x28. DONE is reached after PC 0x28 is written; halt=1. A 16-request drain returns PCs 0x19..0x28 in order with triggered=1; a 17th rd_req gives no rd_valid.
- Flags: regwrite pulse 2 cycles before pcen, memwrite on the pcen cycle. That entry reads back with flags=2'b11; the following entry has flags=2'b00.
- Simultaneous events: arm and pcen in the same cycle -> count=0 afterwards. POST_TRIG=20 with DEPTH=16 clamps to 15, so DONE holds the trigger entry as the oldest of 16.
- Breakpoint enables: bp1=0x05 with bp_en=2'b01 -> no trigger at PC 0x05. With bp_en=2'b10 -> trigger at PC 0x05.

Source files
------------

// File: rtl/trace_capture_unit_pkg.sv
// Shared definitions for the trace capture unit.
// Holds the FSM state encoding (as reported on the 'state' port), the bit
// positions of the per-entry sticky flags, and the stored entry width.
package trace_capture_unit_pkg;

  typedef enum logic [1:0] {
    TCU_IDLE  = 2'd0,
    TCU_ARMED = 2'd1,
    TCU_POST  = 2'd2,
    TCU_DONE  = 2'd3
  } tcu_state_t;

  // Flag field layout inside an entry and on rd_flags: {memwrite_seen, regwrite_seen}
  localparam int FLAG_REGWRITE = 0;
  localparam int FLAG_MEMWRITE = 1;
  localparam int FLAGS_W       = 2;

  // Entry = {pc, instr, flags}; ENTRY_W = WIDTH + INSTR_W + 2
  function automatic int tcu_entry_w(input int width, input int instr_w);
    return width + instr_w + FLAGS_W;
  endfunction

endpackage

// File: rtl/trace_capture_unit_trace_ram.sv
// Trace storage: DEPTH x ENTRY_W array with one synchronous write port and
// one registered read port.
// Ports:
//   clk, reset    clock / asynchronous active-high reset (read register only)
//   we, waddr,    write enable, address and data
//   wdata
//   re, raddr     read enable and address; rdata updates one cycle after re
//   rdata         registered read data; holds its value while re is low
module trace_capture_unit_trace_ram #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 42
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [ENTRY_W-1:0]       wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ENTRY_W-1:0]       rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Array contents carry no reset so the store maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register is reset so the readout bus starts at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/trace_capture_unit.sv
// Debug trace buffer for the multicycle core.
// Records one {pc, instr, flags} entry per pcen cycle into a circular buffer
// while armed, triggers on enabled PC breakpoints, captures a post-trigger
// window, then halts the core and serves the trace oldest-first.
// Ports:
//   clk, reset          clock / asynchronous active-high reset
//   pcen, pcvalue,      core commit-side snoop inputs
//   instr, regwrite,
//   memwrite
//   arm                 pulse: clear buffer and start capture
//   bp_en, bp_addr      breakpoint enables and PCs (bp k at [k*WIDTH +: WIDTH])
//   rd_req              readout request (honoured in DONE only)
//   rd_valid, rd_pc,    readout entry, one cycle after rd_req
//   rd_instr, rd_flags
//   count, state,       status: entries held, FSM state, sticky trigger,
//   triggered, halt     and core halt (high while in DONE)
module trace_capture_unit
  import trace_capture_unit_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int INSTR_W   = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int NUM_BP    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pcen,
  input  logic [WIDTH-1:0]           pcvalue,
  input  logic [INSTR_W-1:0]         instr,
  input  logic                       regwrite,
  input  logic                       memwrite,
  input  logic                       arm,
  input  logic [NUM_BP-1:0]          bp_en,
  input  logic [NUM_BP*WIDTH-1:0]    bp_addr,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_pc,
  output logic [INSTR_W-1:0]         rd_instr,
  output logic [1:0]                 rd_flags,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [1:0]                 state,
  output logic                       triggered,
  output logic                       halt
);

  localparam int ENTRY_W  = tcu_entry_w(WIDTH, INSTR_W);
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = $clog2(DEPTH+1);
  // A post window longer than DEPTH-1 would push the trigger entry out.
  localparam int POST_MAX = (POST_TRIG > DEPTH-1) ? DEPTH-1 : POST_TRIG;

  tcu_state_t         fsm;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      post_cnt;
  logic [1:0]         flags;
  logic [1:0]         flags_now;
  logic [NUM_BP-1:0]  bp_match;
  logic               bp_hit;
  logic               capture;
  logic               readout;
  logic               trigger;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;

  generate
    for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
      assign bp_match[gi] = bp_en[gi] && (pcvalue == bp_addr[gi*WIDTH +: WIDTH]);
    end
  endgenerate
  assign bp_hit = |bp_match;

  // Current-cycle strobes are folded in so a pulse on the pcen cycle is kept.
  always_comb begin
    flags_now = flags;
    flags_now[FLAG_REGWRITE] = flags[FLAG_REGWRITE] | regwrite;
    flags_now[FLAG_MEMWRITE] = flags[FLAG_MEMWRITE] | memwrite;
  end

  // arm wins over both a capture and a readout in the same cycle.
  assign capture = !arm && pcen && (fsm == TCU_ARMED || fsm == TCU_POST);
  assign readout = !arm && rd_req && (fsm == TCU_DONE) && (count != '0);
  assign trigger = capture && (fsm == TCU_ARMED) && bp_hit;
  assign wdata   = {pcvalue, instr, flags_now};

  trace_capture_unit_trace_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (capture),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (readout),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign rd_pc    = rdata[ENTRY_W-1 -: WIDTH];
  assign rd_instr = rdata[FLAGS_W +: INSTR_W];
  assign rd_flags = rdata[FLAGS_W-1:0];
  assign state    = fsm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= TCU_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      flags     <= '0;
      triggered <= 1'b0;
      halt      <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= readout;
      if (arm) begin
        fsm       <= TCU_ARMED;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        post_cnt  <= '0;
        flags     <= '0;
        triggered <= 1'b0;
        halt      <= 1'b0;
      end else begin
        flags <= capture ? 2'b00 : flags_now;
        // capture and readout never coincide: they live in different states.
        if (capture) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (count == CW'(DEPTH)) begin
            rd_ptr <= rd_ptr + 1'b1;   // full: overwrite the oldest entry
          end else begin
            count <= count + 1'b1;
          end
        end
        if (readout) begin
          rd_ptr <= rd_ptr + 1'b1;
          count  <= count - 1'b1;
        end
        case (fsm)
          TCU_ARMED: begin
            if (trigger) begin
              triggered <= 1'b1;
              if (POST_MAX == 0) begin
                fsm  <= TCU_DONE;
                halt <= 1'b1;
              end else begin
                fsm      <= TCU_POST;
                post_cnt <= AW'(POST_MAX);
              end
            end
          end
          TCU_POST: begin
            if (capture) begin
              post_cnt <= post_cnt - 1'b1;
              if (post_cnt == AW'(1)) begin
                fsm  <= TCU_DONE;
                halt <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
